// File: rtl/vram_write_queue.sv
// Screen-write queue between the Hack CPU data bus and the shared VRAM write port.
// Optional build macro VRAM_WQ_COALESCE_EN merges a write into the newest queued same-address entry.

module vram_write_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_wren,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        vram_wren,
    output logic [13:0] vram_waddr,
    output logic [15:0] vram_wdata,
    input  logic        vram_wrack,
    output logic        overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_t;

    state_t        state;
    logic [29:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          full;
    logic          empty;
    logic          screen;
    logic          push;
    logic          pop;
    logic          coalesce;
    logic [13:0]   waddr_in;

    // 0x4000..0x5FFF is exactly the range with addr[14:13] == 2'b10
    assign screen    = cpu_wren && (cpu_addr[14:13] == 2'b10);
    assign waddr_in  = cpu_addr[13:0];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign cpu_ready = !full;
    assign pop       = (state == StIdle) && !empty;

`ifdef VRAM_WQ_COALESCE_EN
    logic [PW-1:0] tail_ptr;

    assign tail_ptr = wr_ptr - PW'(1);
    // The newest entry is off limits once it is being moved into the output registers.
    assign coalesce = screen && !empty && (mem[tail_ptr][29:16] == waddr_in)
                      && !(pop && (count == CW'(1)));
`else
    assign coalesce = 1'b0;
`endif

    assign push = screen && !full && !coalesce;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {waddr_in, cpu_wdata};
        end
`ifdef VRAM_WQ_COALESCE_EN
        else if (coalesce) begin
            mem[tail_ptr][15:0] <= cpu_wdata;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // Full is judged on the registered count, so a same-cycle pop does not save it.
            if (screen && full && !coalesce) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            vram_wren  <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (!empty) begin
                        {vram_waddr, vram_wdata} <= mem[rd_ptr];
                        vram_wren                <= 1'b1;
                        state                    <= StIssue;
                    end
                end
                StIssue: begin
                    if (vram_wrack) begin
                        vram_wren <= 1'b0;
                        state     <= StGap;
                    end
                end
                StGap: begin
                    state <= StIdle;
                end
                default: begin
                    vram_wren <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/vram_write_queue.md
VRAM_WRITE_QUEUE -- requirements
Module: vram_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count, power of two, 2..16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_wren  input  1  CPU memory write strobe, one cycle per write.
REQ-005 cpu_addr  input  15  Hack data-memory address of the write.
REQ-006 cpu_wdata  input  16  write data.
REQ-007 cpu_ready  output  1  high when the queue can accept a write this cycle.
REQ-008 vram_wren  output  1  write request to the shared VRAM write port.
REQ-009 vram_waddr  output  14  VRAM word address, 0..8191.
REQ-010 vram_wdata  output  16  VRAM write data.
REQ-011 vram_wrack  input  1  VRAM write acknowledge, one-cycle pulse.
REQ-012 overflow  output  1  sticky flag: a screen write was dropped.

Function
REQ-013 A write SHALL be a screen write when cpu_wren=1 and cpu_addr is in 0x4000..0x5FFF; all other writes are ignored with no state change.
REQ-014 Screen write SHALL enqueue {cpu_addr-0x4000 (14 bits), cpu_wdata} at FIFO tail when the FIFO is not full.
REQ-015 cpu_ready SHALL equal !full, from registered count only.
REQ-016 A screen write while full SHALL be dropped and SHALL set overflow, even if a pop occurs the same cycle.
REQ-017 Issue FSM states: IDLE, ISSUE, GAP.
REQ-018 IDLE: if FIFO non-empty, pop head into vram_waddr/vram_wdata, set vram_wren=1, go to ISSUE next cycle.
REQ-019 ISSUE: vram_wren, vram_waddr, vram_wdata held stable until vram_wrack is sampled high.
REQ-020 ISSUE with vram_wrack=1: vram_wren=0 next cycle, go to GAP.
REQ-021 GAP: lasts exactly one cycle with vram_wren=0, then IDLE.
REQ-022 Minimum spacing between two vram_wren assertions SHALL be 3 cycles; latency from enqueue into empty idle queue to vram_wren=1 SHALL be 1 cycle.
REQ-023 vram_wrack while not in ISSUE SHALL be ignored.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-025 Entries SHALL reach VRAM in enqueue order.

Reset
REQ-026 reset_n low SHALL asynchronously set: state IDLE, count 0, pointers 0, vram_wren 0, vram_waddr 0, vram_wdata 0, overflow 0, cpu_ready 1.
REQ-027 Reset mid-ISSUE SHALL abandon the in-flight write and flush all queued entries.
REQ-028 overflow SHALL clear only on reset.

Configuration
REQ-029 Macro VRAM_WQ_COALESCE_EN: when defined, a screen write whose VRAM address equals the newest queued (not yet popped) entry SHALL overwrite that entry's data in place, without changing count and without setting overflow even when full.
REQ-030 Without VRAM_WQ_COALESCE_EN every screen write SHALL occupy its own entry; the entry in the output registers is never coalesced in either build.

Verification
REQ-031 Single write 0x4000/0xFFFF into idle queue -> vram_wren=1 next cycle, waddr 0, wdata 0xFFFF; wrack after 5 cycles -> wren 0 next cycle, held stable until then.
REQ-032 Write to 0x3FFF and 0x6000 -> no vram_wren, count stays 0, overflow 0.
REQ-033 DEPTH=4, wrack held low, 6 back-to-back writes 0x4001..0x4006 -> first popped, 4 queued, cpu_ready 0, sixth dropped, overflow 1; releasing wrack yields 0x0001..0x0005 in order.
REQ-034 wrack tied high, 3 queued writes -> wren pulses at cycles N, N+3, N+6.
REQ-035 Coalesce build: wrack low, writes 0x5FFF/0x1111 twice then 0x5FFF/0x2222 -> two entries total, second VRAM write data 0x2222; non-coalesce build -> three VRAM writes.
REQ-036 reset_n low during ISSUE with 2 queued -> wren 0 immediately, queue empty, no further writes after release.
